// File: rtl/reaction_timer_ctrl.sv
// Reaction timer control core: idle prompt, random wait, stimulus LED,
// then a 4-digit BCD millisecond count shown as X.XXX seconds.
// Ports: clk, reset (async, active-low), clear/start/stop (1-cycle pulses),
//   led (stimulus, 1 = lit), d3..d0 (active-low segments {dp,g,f,e,d,c,b,a},
//   d3 leftmost, registered).
module reaction_timer_ctrl #(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned MIN_WAIT_MS = 2000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       start,
  input  logic       stop,
  output logic       led,
  output logic [7:0] d3,
  output logic [7:0] d2,
  output logic [7:0] d1,
  output logic [7:0] d0
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [13:0] MINW = 14'(MIN_WAIT_MS);
  localparam logic [7:0] SEG_H = 8'h89;
  localparam logic [7:0] SEG_I = 8'hF9;
  localparam logic [7:0] SEG_BL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    TIME,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0] presc;
  logic          tick;
  logic [15:0]   lfsr;
  logic          fb;
  logic [13:0]   wait_ms, wait_nx;
  logic [15:0]   cnt, cnt_nx;
  logic          led_nx;
  logic [7:0]    d3_nx, d2_nx, d1_nx, d0_nx;

  function automatic logic [7:0] seg(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'd0: s = 8'hC0;
      4'd1: s = 8'hF9;
      4'd2: s = 8'hA4;
      4'd3: s = 8'hB0;
      4'd4: s = 8'h99;
      4'd5: s = 8'h92;
      4'd6: s = 8'h82;
      4'd7: s = 8'hF8;
      4'd8: s = 8'h80;
      4'd9: s = 8'h90;
      default: s = SEG_BL;
    endcase
    return s;
  endfunction

  // Per-digit decimal increment, carry ripples 9 -> 0 upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick = (presc == PMAX);
  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    state_nx = state;
    wait_nx  = wait_ms;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (!clear && start) begin
          state_nx = WAIT;
          wait_nx  = MINW + {1'b0, lfsr[12:0]};
          cnt_nx   = '0;
        end
      end
      WAIT: begin
        if (clear) begin
          state_nx = IDLE;
        end else if (stop) begin
          state_nx = DONE;
          cnt_nx   = 16'h9999;
        end else if (tick) begin
          if (wait_ms <= 14'd1) state_nx = TIME;
          else wait_nx = wait_ms - 14'd1;
        end
      end
      TIME: begin
        if (clear) begin
          state_nx = IDLE;
        end else if (stop) begin
          state_nx = DONE;
        end else if (cnt == 16'h9999) begin
          state_nx = DONE;
        end else if (tick) begin
          cnt_nx = bcd_inc(cnt);
        end
      end
      DONE: begin
        if (clear) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx == IDLE) begin
      wait_nx = '0;
      cnt_nx  = '0;
    end
  end

  // Output patterns are computed from the current registers and then
  // registered, so they trail the state/count by one clock.
  always_comb begin
    led_nx = 1'b0;
    d3_nx  = SEG_BL;
    d2_nx  = SEG_BL;
    d1_nx  = SEG_H;
    d0_nx  = SEG_I;
    unique case (state)
      IDLE: ;
      WAIT: begin
        d1_nx = SEG_BL;
        d0_nx = SEG_BL;
      end
      TIME, DONE: begin
        led_nx = (state == TIME);
        d3_nx  = seg(cnt[15:12]) & 8'h7F;
        d2_nx  = seg(cnt[11:8]);
        d1_nx  = seg(cnt[7:4]);
        d0_nx  = seg(cnt[3:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      presc   <= '0;
      lfsr    <= LFSR_SEED;
      wait_ms <= '0;
      cnt     <= '0;
      led     <= 1'b0;
      d3      <= SEG_BL;
      d2      <= SEG_BL;
      d1      <= SEG_H;
      d0      <= SEG_I;
    end else begin
      state   <= state_nx;
      lfsr    <= {lfsr[14:0], fb};
      wait_ms <= wait_nx;
      cnt     <= cnt_nx;
      // Prescaler restarts on every state entry.
      if (state_nx != state || tick) presc <= '0;
      else presc <= presc + 1'b1;
      led <= led_nx;
      d3  <= d3_nx;
      d2  <= d2_nx;
      d1  <= d1_nx;
      d0  <= d0_nx;
    end
  end

endmodule
